// File: rtl/cpu_trace_buffer_if.sv
// Capture, trigger and read-back signals of the CPU trace buffer.
// The rd_stamp signal exists only when CPU_TRACE_CYCLE_STAMP_EN is defined.
interface cpu_trace_buffer_if #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 22,
    parameter int DEPTH  = 16
);
    localparam int AW = $clog2(DEPTH);

    logic              arm;
    logic              trig_en;
    logic [DATA_W-1:0] trig_pc;
    logic              cap_valid;
    logic [DATA_W-1:0] cap_pc;
    logic [DATA_W-1:0] cap_inst;
    logic [DATA_W-1:0] cap_alu;
    logic [CTRL_W-1:0] cap_ctrl;
    logic              rd_en;
    logic [AW-1:0]     rd_addr;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_pc;
    logic [DATA_W-1:0] rd_inst;
    logic [DATA_W-1:0] rd_alu;
    logic [CTRL_W-1:0] rd_ctrl;
    logic [1:0]        state;
    logic [AW:0]       count;
`ifdef CPU_TRACE_CYCLE_STAMP_EN
    logic [15:0]       rd_stamp;
`endif

    modport master (
        output arm, trig_en, trig_pc, cap_valid, cap_pc, cap_inst, cap_alu, cap_ctrl,
               rd_en, rd_addr,
        input  rd_valid, rd_pc, rd_inst, rd_alu, rd_ctrl, state, count
`ifdef CPU_TRACE_CYCLE_STAMP_EN
        , input rd_stamp
`endif
    );

    modport slave (
        input  arm, trig_en, trig_pc, cap_valid, cap_pc, cap_inst, cap_alu, cap_ctrl,
               rd_en, rd_addr,
        output rd_valid, rd_pc, rd_inst, rd_alu, rd_ctrl, state, count
`ifdef CPU_TRACE_CYCLE_STAMP_EN
        , output rd_stamp
`endif
    );
endinterface

// File: rtl/cpu_trace_buffer.sv
// Circular trace capture of CPU debug signals with PC-match trigger and indexed read-back.
// Optional per-entry 16-bit cycle stamp: define CPU_TRACE_CYCLE_STAMP_EN.
module cpu_trace_buffer #(
    parameter int DATA_W    = 32,
    parameter int CTRL_W    = 22,
    parameter int DEPTH     = 16,
    parameter int POST_TRIG = 8
) (
    input  logic              clk,
    input  logic              reset,
    cpu_trace_buffer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int PT = (POST_TRIG > DEPTH - 1) ? DEPTH - 1 : POST_TRIG;
    localparam logic [AW:0]   FULL = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] PT_V = AW'(PT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        POST  = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef struct packed {
`ifdef CPU_TRACE_CYCLE_STAMP_EN
        logic [15:0]       stamp;
`endif
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] inst;
        logic [DATA_W-1:0] alu;
        logic [CTRL_W-1:0] ctrl;
    } entry_t;

    state_t        st;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] post_cnt;
    logic [AW:0]   count;
    entry_t        mem [DEPTH];
    entry_t        wr_entry;
    entry_t        rd_q;
    logic          rd_valid_q;
    logic          wr_en;
    logic          trig_hit;
    logic          rd_ok;
    logic [AW-1:0] phys;

`ifdef CPU_TRACE_CYCLE_STAMP_EN
    logic [15:0] stamp;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) stamp <= '0;
        else       stamp <= stamp + 16'd1;
    end

    assign wr_entry.stamp = stamp;
    assign bus.rd_stamp   = rd_q.stamp;
`endif

    assign wr_entry.pc   = bus.cap_pc;
    assign wr_entry.inst = bus.cap_inst;
    assign wr_entry.alu  = bus.cap_alu;
    assign wr_entry.ctrl = bus.cap_ctrl;

    // arm takes priority over both capture and read in the same cycle
    assign wr_en    = (st == ARMED || st == POST) && bus.cap_valid && !bus.arm;
    assign trig_hit = bus.trig_en && (bus.cap_pc == bus.trig_pc);
    assign rd_ok    = bus.rd_en && !bus.arm && (st == IDLE || st == DONE)
                      && ({1'b0, bus.rd_addr} < count);
    // once wrapped, the oldest entry sits at the write pointer
    assign phys     = ((count == FULL) ? wr_ptr : '0) + bus.rd_addr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st       <= IDLE;
            wr_ptr   <= '0;
            count    <= '0;
            post_cnt <= '0;
        end else if (bus.arm) begin
            st       <= ARMED;
            wr_ptr   <= '0;
            count    <= '0;
            post_cnt <= '0;
        end else if (wr_en) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (count != FULL) count <= count + 1'b1;
            if (st == ARMED) begin
                if (trig_hit) begin
                    if (PT == 0) begin
                        st <= DONE;
                    end else begin
                        st       <= POST;
                        post_cnt <= PT_V;
                    end
                end
            end else begin
                post_cnt <= post_cnt - 1'b1;
                if (post_cnt == AW'(1)) st <= DONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_entry;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_valid_q <= 1'b0;
            rd_q       <= '0;
        end else begin
            rd_valid_q <= rd_ok;
            rd_q       <= rd_ok ? mem[phys] : '0;
        end
    end

    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_pc    = rd_q.pc;
    assign bus.rd_inst  = rd_q.inst;
    assign bus.rd_alu   = rd_q.alu;
    assign bus.rd_ctrl  = rd_q.ctrl;
    assign bus.state    = st;
    assign bus.count    = count;
endmodule
